sipo_deser: RTL

Serial-in, parallel-out deserializer that receives the bit stream produced by the team's parallel-to-serial path. It assembles WIDTH serial bits into a parallel word and presents the word on a valid/ready output port. A one-word holding register lets the next word shift in while the current word waits for the consumer. A sticky flag reports words lost to overrun.

---
 rtl/sipo_deser.sv | 96 +++++++++
 1 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with a one-word
// holding register on a valid/ready output and a sticky overrun flag.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    k;
  logic [CW-1:0]    pos;
  logic             hold_full;
  logic             s_sync;
  logic             s_shift;
  logic             s_last;
  logic             done;
  logic             accept;
  logic             load;
  logic             drop;

  assign s_sync  = sin_valid & sin_sync;
  assign s_shift = sin_valid & ~sin_sync & (cnt != LAST);
  assign s_last  = sin_valid & ~sin_sync & (cnt == LAST);

  // sync forces the incoming bit to be bit 0 of a fresh word
  assign k   = sin_sync ? '0 : cnt;
  assign pos = MSB_FIRST ? (LAST - k) : k;

  always_comb begin
    sreg_nx = sreg;
    cnt_nx  = cnt;
    word    = sreg;
    done    = 1'b0;
    unique case (1'b1)
      s_sync: begin
        sreg_nx      = '0;
        sreg_nx[pos] = sin;
        cnt_nx       = CW'(1);
      end
      s_shift: begin
        sreg_nx[pos] = sin;
        cnt_nx       = cnt + CW'(1);
      end
      s_last: begin
        word[pos] = sin;
        done      = 1'b1;
        sreg_nx   = '0;
        cnt_nx    = '0;
      end
      default: ;
    endcase
  end

  assign accept = hold_full & dout_ready;
  assign load   = done & (~hold_full | dout_ready);
  assign drop   = done & hold_full & ~dout_ready;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sreg      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      dout      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sreg      <= sreg_nx;
      cnt       <= cnt_nx;
      busy      <= (cnt_nx != '0);
      hold_full <= load | (hold_full & ~accept);
      overrun   <= drop | (overrun & ~ovr_clr);
      if (load) dout <= word;
    end
  end

  assign dout_valid = hold_full;

endmodule
